fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of instruction_memory: it generates the PC, drives the memory word address, and absorbs the memory's 1-cycle registered read latency.
- Presents {pc, instr} to decode through a valid/ready handshake.
- Supports redirect (branch/jump/trap) and downstream backpressure with no lost or duplicated instructions.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch unit and its skid FIFO both exchange fetch_entry_t.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries; the head is held in a register so the
// downstream outputs never see a combinational path from the memory.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head   <= '0;
      tail_q <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail_q <= din;
            count  <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: the issue credit rule never pushes here without a pop.
          if (pop) begin
            head <= tail_q;
            if (push) begin
              tail_q <= din;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, issue credit control and capture
// of the 1-cycle registered instruction memory read into a skid FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              IMEM_DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] RESET_PC         = 32'h0000_0000,
  localparam int             ADDR_WIDTH       = $clog2(IMEM_DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] infl_pc_q;
  logic            infl_q;
  logic [1:0]      fifo_count;
  logic [2:0]      occupancy;
  logic            pop;
  logic            push;
  logic            issue;
  logic            unused_redirect_lsb;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // PC is sliced, not truncated: addresses past the memory alias.
  assign imem_addr = pc_q[ADDR_WIDTH+1:2];

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = infl_q & ~redirect_valid;

  // At most two entries may be held or in flight once this cycle's pop retires.
  assign occupancy = {1'b0, fifo_count} + {2'b00, infl_q};
  assign issue     = en & ~redirect_valid & (occupancy <= ({2'b00, pop} + 3'd1));

  assign push_entry = '{pc: infl_pc_q, instr: imem_instr};

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= {redirect_pc[XLEN-1:2], 2'b00};
      infl_q <= 1'b0;
    end else if (issue) begin
      infl_q    <= 1'b1;
      infl_pc_q <= pc_q;
      pc_q      <= pc_q + 32'd4;
    end else begin
      infl_q <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (fifo_count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule
